// File: rtl/dram_page_bank.sv
// dram_page_bank: multiplexed-address DRAM bank model with fast page mode,
// RAS-only / CBR refresh accounting and odd-parity checking on reads.
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   ma                multiplexed row/column address, max(RW,CW) bits
//   ras_n, cas_n      row / column strobes, active low
//   we_n              write enable, active low
//   din, din_p        write data and host-generated parity bit
//   dout, dout_p      registered read data and stored parity (0 when PARITY=0)
//   dout_en           read data valid / bus drive enable
//   perr              one-cycle parity error pulse on the first read of a CAS
//   ref_cnt           completed refresh cycles (wraps)
//   cbr_row           internal CBR refresh row counter (wraps)
module dram_page_bank #(
    parameter int DW = 8,
    parameter int RW = 8,
    parameter int CW = 8,
    parameter int PARITY = 1,
    localparam int AW = (RW > CW) ? RW : CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ma,
    input  logic          ras_n,
    input  logic          cas_n,
    input  logic          we_n,
    input  logic [DW-1:0] din,
    input  logic          din_p,
    output logic [DW-1:0] dout,
    output logic          dout_p,
    output logic          dout_en,
    output logic          perr,
    output logic [15:0]   ref_cnt,
    output logic [RW-1:0] cbr_row
);
    localparam int MW = (PARITY != 0) ? DW + 1 : DW;

    typedef enum logic [1:0] {IDLE, ROW, COL, CBR} state_t;

    state_t        state, state_n;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          lat_row, lat_col, ref_inc, cbr_inc;
    // cas_seen marks that this RAS already carried a CAS, so a later ras-high
    // from ROW (after page mode) is not mistaken for a RAS-only refresh.
    logic          cas_seen;
    // rd_done limits the parity pulse to the first read cycle of a CAS.
    logic          rd_done;
    logic          rd, wr;
    logic [MW-1:0] mem [0:(2**(RW+CW))-1];
    logic [MW-1:0] rword, wdata;

    assign rd    = (state == COL) && !cas_n && we_n;
    assign wr    = (state == COL) && !we_n;
    assign rword = mem[{row, col}];
    assign wdata = MW'({din_p & (PARITY != 0), din});

    always_comb begin
        state_n = state;
        lat_row = 1'b0;
        lat_col = 1'b0;
        ref_inc = 1'b0;
        cbr_inc = 1'b0;
        case (state)
            IDLE: if (!ras_n) begin
                state_n = cas_n ? ROW : CBR;
                lat_row = cas_n;
            end
            ROW: if (!cas_n) begin
                state_n = COL;
                lat_col = 1'b1;
            end else if (ras_n) begin
                state_n = IDLE;
                ref_inc = !cas_seen;
            end
            COL: if (cas_n) state_n = ras_n ? IDLE : ROW;
            CBR: if (ras_n) begin
                state_n = IDLE;
                ref_inc = 1'b1;
                cbr_inc = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            row      <= '0;
            col      <= '0;
            dout     <= '0;
            dout_p   <= 1'b0;
            dout_en  <= 1'b0;
            perr     <= 1'b0;
            ref_cnt  <= '0;
            cbr_row  <= '0;
            cas_seen <= 1'b0;
            rd_done  <= 1'b0;
        end else begin
            state   <= state_n;
            ref_cnt <= ref_cnt + 16'(ref_inc);
            cbr_row <= cbr_row + RW'(cbr_inc);
            dout_en <= rd;
            // Odd parity: a good word XORs to 1 across data and parity bit.
            perr    <= rd && !rd_done && (PARITY != 0) && !(^rword);
            if (lat_row) begin
                row      <= ma[RW-1:0];
                cas_seen <= 1'b0;
            end
            if (lat_col) begin
                col      <= ma[CW-1:0];
                cas_seen <= 1'b1;
                rd_done  <= 1'b0;
            end
            if (rd) begin
                dout    <= rword[DW-1:0];
                dout_p  <= (PARITY != 0) && rword[MW-1];
                rd_done <= 1'b1;
            end
        end
    end

    // Array is deliberately outside the reset domain; rst only blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && wr) mem[{row, col}] <= wdata;
    end
endmodule

// File: tb/tb_dram_page_bank.sv
// tb_dram_page_bank: self-checking bench for dram_page_bank (PARITY=1 and PARITY=0 instances).
module tb_dram_page_bank;
    logic       clk, rst, ras_n, cas_n, we_n, din_p;
    logic [7:0] ma, din;
    logic [7:0] dout, dout0;
    logic [15:0] ref_cnt, ref_cnt0;
    logic [7:0] cbr_row, cbr_row0;
    logic       dout_p, dout_en, perr, dout_p0, dout_en0, perr0;

    dram_page_bank #(.DW(8), .RW(8), .CW(8), .PARITY(1)) dut (
        .clk(clk), .rst(rst), .ma(ma), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
        .din(din), .din_p(din_p), .dout(dout), .dout_p(dout_p), .dout_en(dout_en),
        .perr(perr), .ref_cnt(ref_cnt), .cbr_row(cbr_row)
    );

    dram_page_bank #(.DW(8), .RW(8), .CW(8), .PARITY(0)) dut0 (
        .clk(clk), .rst(rst), .ma(ma), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
        .din(din), .din_p(din_p), .dout(dout0), .dout_p(dout_p0), .dout_en(dout_en0),
        .perr(perr0), .ref_cnt(ref_cnt0), .cbr_row(cbr_row0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       pe;
    } exp_t;

    typedef struct {
        logic        r, c, w;
        logic [7:0]  a, d;
        logic        en;
        logic [15:0] rc;
        logic [7:0]  cr;
    } vec_t;

    exp_t       sb[$];
    logic [8:0] rm [0:65535];
    logic [7:0] cur_row;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic c, input logic w,
                         input logic [7:0] a, input logic [7:0] d, input logic p);
        ras_n = r; cas_n = c; we_n = w; ma = a; din = d; din_p = p;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        drive(1, 1, 1, 8'h00, 8'h00, 0);
        rst = 1'b0;
    endtask

    task automatic open_row(input logic [7:0] r);
        cur_row = r;
        drive(0, 1, 1, r, 8'h00, 0);
    endtask

    task automatic close_row();
        drive(1, 1, 1, 8'h00, 8'h00, 0);
    endtask

    task automatic cas_write(input logic [7:0] c, input logic [7:0] d, input logic p);
        drive(0, 0, 0, c, d, p);
        drive(0, 0, 0, c, d, p);
        rm[{cur_row, c}] = {p, d};
        drive(0, 1, 1, c, d, p);
    endtask

    task automatic cas_read(input logic [7:0] c, input int n);
        exp_t e;
        logic [8:0] w;
        w = rm[{cur_row, c}];
        drive(0, 0, 1, c, 8'h00, 0);
        chk("cas_latency_en", dout_en, 0);
        for (int i = 0; i < n; i++) begin
            e.d = w[7:0];
            e.p = w[8];
            e.pe = (i == 0) && !(^w);
            sb.push_back(e);
            drive(0, 0, 1, c, 8'h00, 0);
            chk("read_en", dout_en, 1);
        end
        drive(0, 1, 1, c, 8'h00, 0);
        chk("en_drop", dout_en, 0);
        chk("dout_hold", dout, w[7:0]);
    endtask

    // Scoreboard monitor: every valid read cycle must match the next expected word.
    always @(negedge clk) begin
        if (!rst) begin
            if (dout_en) begin
                if (sb.size() == 0) begin
                    chk("unexpected_dout_en", dout_en, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_dout", dout, e.d);
                    chk("sb_dout_p", dout_p, e.p);
                    chk("sb_perr", perr, e.pe);
                    chk("p0_en", dout_en0, 1);
                    chk("p0_dout", dout0, e.d);
                    chk("p0_dout_p", dout_p0, 0);
                    chk("p0_perr", perr0, 0);
                end
            end else if (perr) begin
                chk("perr_without_read", perr, 0);
            end
        end
    end

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{0, 1, 1, 8'h20, 8'h00, 0, 16'd0, 8'd0};
        tbl[1]  = '{1, 1, 1, 8'h00, 8'h00, 0, 16'd1, 8'd0};
        tbl[2]  = '{0, 1, 1, 8'h21, 8'h00, 0, 16'd1, 8'd0};
        tbl[3]  = '{1, 1, 1, 8'h00, 8'h00, 0, 16'd2, 8'd0};
        tbl[4]  = '{1, 0, 0, 8'h34, 8'hFF, 0, 16'd2, 8'd0};
        tbl[5]  = '{0, 1, 1, 8'h22, 8'h00, 0, 16'd2, 8'd0};
        tbl[6]  = '{1, 1, 1, 8'h00, 8'h00, 0, 16'd3, 8'd0};
        tbl[7]  = '{0, 0, 1, 8'h00, 8'h00, 0, 16'd3, 8'd0};
        tbl[8]  = '{0, 0, 1, 8'h00, 8'h00, 0, 16'd3, 8'd0};
        tbl[9]  = '{1, 1, 1, 8'h00, 8'h00, 0, 16'd4, 8'd1};
        tbl[10] = '{0, 0, 1, 8'h00, 8'h00, 0, 16'd4, 8'd1};
        tbl[11] = '{1, 0, 1, 8'h00, 8'h00, 0, 16'd5, 8'd2};
        tbl[12] = '{1, 1, 1, 8'h00, 8'h00, 0, 16'd5, 8'd2};

        rst = 1'b1; ras_n = 1; cas_n = 1; we_n = 1; ma = 0; din = 0; din_p = 0;
        cur_row = 0;
        @(negedge clk);
        reset_pulse();
        chk("rst_dout", dout, 0);
        chk("rst_dout_p", dout_p, 0);
        chk("rst_dout_en", dout_en, 0);
        chk("rst_perr", perr, 0);
        chk("rst_ref_cnt", ref_cnt, 0);
        chk("rst_cbr_row", cbr_row, 0);

        open_row(8'h12);
        cas_write(8'h34, 8'hA5, 1);
        cas_read(8'h34, 1);
        close_row();
        chk("wr_rd_ref_cnt", ref_cnt, 0);

        reset_pulse();
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].r, tbl[i].c, tbl[i].w, tbl[i].a, tbl[i].d, 0);
            chk($sformatf("tbl%0d_en", i), dout_en, tbl[i].en);
            chk($sformatf("tbl%0d_ref", i), ref_cnt, tbl[i].rc);
            chk($sformatf("tbl%0d_cbr", i), cbr_row, tbl[i].cr);
        end
        open_row(8'h12);
        cas_read(8'h34, 1);
        close_row();

        reset_pulse();
        for (int i = 0; i < 256; i++) begin
            drive(0, 0, 1, 8'h00, 8'h00, 0);
            drive(1, 1, 1, 8'h00, 8'h00, 0);
            if (i == 254) chk("cbr_row_255", cbr_row, 255);
        end
        chk("cbr_row_wrap", cbr_row, 0);
        chk("cbr_ref_cnt", ref_cnt, 256);

        open_row(8'h01);
        for (int c = 0; c < 4; c++) begin
            logic [7:0] d;
            d = 8'h10 + 8'(c);
            cas_write(8'(c), d, ~^d);
        end
        for (int c = 0; c < 4; c++) cas_read(8'(c), 1);
        close_row();
        chk("page_ref_cnt", ref_cnt, 256);

        open_row(8'h05);
        cas_write(8'h07, 8'h03, 0);
        cas_read(8'h07, 3);
        close_row();
        drive(1, 1, 1, 8'h00, 8'h00, 0);
        chk("perr_gone", perr, 0);

        open_row(8'h12);
        drive(0, 0, 0, 8'h34, 8'h5A, 1);
        rst = 1'b1;
        drive(0, 0, 0, 8'h34, 8'h5A, 1);
        chk("mid_rst_dout", dout, 0);
        chk("mid_rst_en", dout_en, 0);
        chk("mid_rst_ref", ref_cnt, 0);
        chk("mid_rst_cbr", cbr_row, 0);
        rst = 1'b0;
        drive(1, 1, 1, 8'h00, 8'h00, 0);
        open_row(8'h12);
        cas_read(8'h34, 1);
        close_row();
        chk("post_rst_ref", ref_cnt, 0);

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
